// File: rtl/conv_host_mem.sv
// Host/memory responder for the CONV engine: loads the input image from a
// host stream, serves zero-latency image and layer reads, captures layer
// writes, and streams the max-pool layer back to the host when the engine is done.
module conv_host_mem #(
    parameter int DW        = 20,
    parameter int AW        = 12,
    parameter int IMG_WORDS = 4096,
    parameter int L1_WORDS  = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          start,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          dout_valid,
    output logic [DW-1:0] dout_data,
    output logic          dout_last,
    input  logic          dout_ready,
    output logic          done,
    output logic          err
);
    localparam int IW = $clog2(IMG_WORDS);
    localparam int LW = $clog2(L1_WORDS);

    typedef enum logic [2:0] {S_LOAD, S_READY, S_RUN, S_DUMP, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] lcnt_q, lcnt_d;
    logic [LW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;

    // Arrays carry no reset: contents survive a reset by design.
    logic [DW-1:0] img [IMG_WORDS];
    logic [DW-1:0] l0  [IMG_WORDS];
    logic [DW-1:0] l1  [L1_WORDS];

    logic ld_acc, l1_in_range, l0_we, l1_we, dump_hs;

    assign ld_acc      = ld_valid && (state_q == S_LOAD);
    assign l1_in_range = caddr_wr < AW'(L1_WORDS);
    assign l0_we       = cwr && (state_q == S_RUN) && (csel == 3'b001);
    assign l1_we       = cwr && (state_q == S_RUN) && (csel == 3'b011) && l1_in_range;
    assign dump_hs     = (state_q == S_DUMP) && dout_ready;

    assign ld_ready   = (state_q == S_LOAD);
    assign ready      = (state_q == S_READY);
    assign dout_valid = (state_q == S_DUMP);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign idata      = img[iaddr[IW-1:0]];
    assign dout_data  = l1[ptr_q];
    assign dout_last  = (state_q == S_DUMP) && (ptr_q == LW'(L1_WORDS - 1));

    // Zero-latency layer read; out-of-range L1 addresses and unknown banks read 0.
    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            if (csel == 3'b001)
                cdata_rd = l0[caddr_rd[IW-1:0]];
            else if (csel == 3'b011 && caddr_rd < AW'(L1_WORDS))
                cdata_rd = l1[caddr_rd[LW-1:0]];
        end
    end

    // Memory writes: image from the host stream, layers from the engine.
    always_ff @(posedge clk) begin
        if (ld_acc) img[lcnt_q]            <= ld_data;
        if (l0_we)  l0[caddr_wr[IW-1:0]]   <= cdata_wr;
        if (l1_we)  l1[caddr_wr[LW-1:0]]   <= cdata_wr;
    end

    // Control state, counters and sticky error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LOAD;
            lcnt_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: load -> ready -> run -> dump -> done, plus error capture.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        if (cwr && state_q != S_RUN) err_d = 1'b1;
        if (cwr && state_q == S_RUN && csel == 3'b011 && !l1_in_range) err_d = 1'b1;
        unique case (state_q)
            S_LOAD: if (ld_acc) begin
                lcnt_d = lcnt_q + 1'b1;
                if (lcnt_q == IW'(IMG_WORDS - 1)) state_d = S_READY;
            end
            S_READY: if (busy) state_d = S_RUN;
            S_RUN: if (!busy) begin
                state_d = S_DUMP;
                ptr_d   = '0;
            end
            S_DUMP: if (dump_hs) begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LW'(L1_WORDS - 1)) state_d = S_DONE;
            end
            S_DONE: if (start) begin
                state_d = S_LOAD;
                lcnt_d  = '0;
                ptr_d   = '0;
                err_d   = 1'b0;
            end
            default: state_d = S_LOAD;
        endcase
    end
endmodule

// File: tb/tb_conv_host_mem.sv
// Directed bench for conv_host_mem: load, engine handshake, layer access,
// error capture, backpressured dump, restart and reset mid-dump.
module tb_conv_host_mem;
    localparam int DW = 20, AW = 12;

    logic          clk = 1'b0, reset = 1'b1;
    logic          ld_valid = 1'b0, start = 1'b0, busy = 1'b0;
    logic [DW-1:0] ld_data = '0, cdata_wr = '0;
    logic [AW-1:0] iaddr = '0, caddr_wr = '0, caddr_rd = '0;
    logic          cwr = 1'b0, crd = 1'b0, dout_ready = 1'b0;
    logic [2:0]    csel = 3'b000;
    logic          ld_ready, ready, dout_valid, dout_last, done, err;
    logic [DW-1:0] idata, cdata_rd, dout_data;

    int total = 0, bad = 0;

    conv_host_mem dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .start(start), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .dout_valid(dout_valid), .dout_data(dout_data),
        .dout_last(dout_last), .dout_ready(dout_ready), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic do_load(input logic [DW-1:0] off);
        for (int k = 0; k < 4096; k++) begin
            ld_valid = 1'b1;
            ld_data  = DW'(k) + off;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL rst_ld_ready got=%b exp=1", ld_ready); end
        total++; if ({ready, dout_valid, dout_last, done, err} !== 5'b0) begin
            bad++; $display("FAIL rst_outs got=%b exp=00000", {ready, dout_valid, dout_last, done, err});
        end
        reset = 1'b0;
    endtask

    task automatic test_load;
        @(posedge clk); #1;
        for (int k = 0; k < 4096; k++) begin
            if (k % 7 == 3) begin
                ld_valid = 1'b0;
                @(posedge clk); #1;
            end
            ld_valid = 1'b1;
            ld_data  = DW'(k);
            #1;
            total++; if (ld_ready !== 1'b1 || ready !== 1'b0) begin
                bad++; $display("FAIL load_hs k=%0d ld_ready=%b ready=%b exp 1/0", k, ld_ready, ready);
            end
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        total++; if (ready !== 1'b1 || ld_ready !== 1'b0) begin
            bad++; $display("FAIL load_ready got ready=%b ld_ready=%b exp 1/0", ready, ld_ready);
        end
        iaddr = 12'h0A5; #1;
        total++; if (idata !== 20'h000A5) begin bad++; $display("FAIL idata got=%h exp=000a5", idata); end
    endtask

    task automatic test_ignore_ld;
        ld_valid = 1'b1; ld_data = 20'hFFFFF;
        @(posedge clk); #1;
        ld_valid = 1'b0; iaddr = 12'h000; #1;
        total++; if (idata !== 20'h00000) begin bad++; $display("FAIL ld_ignored got=%h exp=00000", idata); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_hold got=%b exp=1", ready); end
    endtask

    task automatic test_run_rw;
        busy = 1'b1;
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL ready_drop got=%b exp=0", ready); end
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd65; cdata_wr = 20'h0ABCD;
        @(posedge clk); #1;
        cdata_wr = 20'h0BEEF; crd = 1'b1; caddr_rd = 12'd65; #1;
        total++; if (cdata_rd !== 20'h0ABCD) begin bad++; $display("FAIL rd_old got=%h exp=0abcd", cdata_rd); end
        @(posedge clk); #1;
        csel = 3'b001; cdata_wr = 20'h01310;
        @(posedge clk); #1;
        cwr = 1'b0; #1;
        total++; if (cdata_rd !== 20'h01310) begin bad++; $display("FAIL l0_rd got=%h exp=01310", cdata_rd); end
        csel = 3'b011; #1;
        total++; if (cdata_rd !== 20'h0BEEF) begin bad++; $display("FAIL l1_rd got=%h exp=0beef", cdata_rd); end
        crd = 1'b0; #1;
        total++; if (cdata_rd !== 20'h00000) begin bad++; $display("FAIL rd_idle got=%h exp=00000", cdata_rd); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clean got=%b exp=0", err); end
    endtask

    task automatic test_err;
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd0; cdata_wr = 20'h11111;
        @(posedge clk); #1;
        caddr_wr = 12'd1024; cdata_wr = 20'h22222;
        @(posedge clk); #1;
        caddr_wr = 12'd1023; cdata_wr = 20'h33333;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_range got=%b exp=1", err); end
        @(posedge clk); #1;
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd0; #1;
        total++; if (cdata_rd !== 20'h11111) begin bad++; $display("FAIL l1_no_alias got=%h exp=11111", cdata_rd); end
        caddr_rd = 12'd1024; #1;
        total++; if (cdata_rd !== 20'h00000) begin bad++; $display("FAIL l1_oob_rd got=%h exp=00000", cdata_rd); end
        caddr_rd = 12'd1023; #1;
        total++; if (cdata_rd !== 20'h33333) begin bad++; $display("FAIL l1_top got=%h exp=33333", cdata_rd); end
        crd = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    endtask

    task automatic test_dump;
        int idx = 0;
        logic hs;
        cwr = 1'b1; csel = 3'b011;
        for (int i = 0; i < 1024; i++) begin
            caddr_wr = AW'(i); cdata_wr = DW'(i);
            @(posedge clk); #1;
        end
        cwr = 1'b0; busy = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            #1;
            total++; if (dout_valid !== 1'b1 || dout_data !== 20'h0 || dout_last !== 1'b0) begin
                bad++; $display("FAIL dump_stall c=%0d valid=%b data=%h last=%b exp 1/00000/0", c, dout_valid, dout_data, dout_last);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int c = 0; c < 10000 && idx < 1024; c++) begin
            dout_ready = ($urandom_range(0, 1) == 1);
            #1;
            hs = dout_valid && dout_ready;
            if (hs) begin
                total++; if (dout_data !== DW'(idx) || dout_last !== (idx == 1023)) begin
                    bad++; $display("FAIL dump_word idx=%0d data=%h last=%b", idx, dout_data, dout_last);
                end
            end
            @(posedge clk); #1;
            if (hs) idx++;
        end
        dout_ready = 1'b0;
        total++; if (idx != 1024) begin bad++; $display("FAIL dump_count got=%0d exp=1024", idx); end
        #1;
        total++; if (done !== 1'b1 || dout_valid !== 1'b0) begin
            bad++; $display("FAIL dump_done done=%b valid=%b exp 1/0", done, dout_valid);
        end
    endtask

    task automatic test_done;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_in_done got=%b exp=1", err); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (ld_ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL restart ld_ready=%b err=%b done=%b exp 1/0/0", ld_ready, err, done);
        end
        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd65; cdata_wr = 20'h00000;
        @(posedge clk); #1;
        cwr = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_cwr_load got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid;
        do_load(20'h00100);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reload1_ready got=%b exp=1", ready); end
        busy = 1'b1; @(posedge clk); #1;
        busy = 1'b0; @(posedge clk); #1;
        dout_ready = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        dout_ready = 1'b0; #1;
        total++; if (dout_valid !== 1'b1 || dout_data !== 20'd300) begin
            bad++; $display("FAIL dump_300 valid=%b data=%h exp 1/0012c", dout_valid, dout_data);
        end
        reset = 1'b1; #1;
        total++; if (dout_valid !== 1'b0 || ld_ready !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL mid_reset valid=%b ld_ready=%b err=%b exp 0/1/0", dout_valid, ld_ready, err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        do_load(20'h00200);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reload2_ready got=%b exp=1", ready); end
        iaddr = 12'd5; #1;
        total++; if (idata !== 20'h00205) begin bad++; $display("FAIL reload_img got=%h exp=00205", idata); end
        crd = 1'b1; csel = 3'b001; caddr_rd = 12'd65; #1;
        total++; if (cdata_rd !== 20'h01310) begin bad++; $display("FAIL l0_kept got=%h exp=01310", cdata_rd); end
        csel = 3'b011; caddr_rd = 12'd700; #1;
        total++; if (cdata_rd !== 20'd700) begin bad++; $display("FAIL l1_kept got=%h exp=002bc", cdata_rd); end
        crd = 1'b0;
    endtask

    initial begin
        test_reset;
        test_load;
        test_ignore_ld;
        test_run_rw;
        test_err;
        test_dump;
        test_done;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
